mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR, default 4, meaning the ROM address MSB index (the address width is MEM_ADDR+1).
REQ-002 SHALL have parameter MEM_EXTRA, default 4, meaning the extra-bytes field width (data width is 2**MEM_EXTRA*8).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports p0_req / p1_req  in  1  access request from requester 0 (fetch) and requester 1 (data).
REQ-006 SHALL have ports p0_addr / p1_addr  in  MEM_ADDR+1  requested address.
REQ-007 SHALL have ports p0_extra / p1_extra  in  MEM_EXTRA  requested extra-bytes count.
REQ-008 SHALL have ports p0_gnt / p1_gnt  out  1  one-cycle grant pulse; the request was accepted.
REQ-009 SHALL have ports p0_valid / p1_valid  out  1  one-cycle pulse; rd_data and rd_error belong to this requester.
REQ-010 SHALL have port rd_data  out  2**MEM_EXTRA*8  read data, shared by both requesters.
REQ-011 SHALL have port rd_error  out  1  bound error for the returned access.
REQ-012 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-013 SHALL have ports mem_addr  out  MEM_ADDR+1 and mem_extra  out  MEM_EXTRA, both registered and driving genrom.
REQ-014 SHALL have ports mem_data  in  2**MEM_EXTRA*8 and mem_error  in  1, from genrom with 1-cycle registered latency.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, RETURN.
REQ-016 SHALL, in IDLE with at least one req high at a clock edge, select a winner, latch its addr/extra into mem_addr/mem_extra, record the owner, and go to ISSUE.
REQ-017 SHALL assert the winner's gnt for exactly the ISSUE cycle.
REQ-018 SHALL go from ISSUE to RETURN unconditionally (genrom samples mem_addr on this edge).
REQ-019 SHALL, on the edge leaving RETURN, capture mem_data into rd_data and mem_error into rd_error, and pulse the owner's valid for the following cycle (spent in IDLE).
REQ-020 SHALL give a fixed latency of arbitration edge T -> gnt in cycle T+1 -> valid in cycle T+3.
REQ-021 SHALL allow re-arbitration during the IDLE cycle in which valid is high, for a throughput of one access per 3 cycles.
REQ-022 SHALL, when only one req is high, select that requester.
REQ-023 SHALL, when both reqs are high, select the requester not granted last (round-robin); the last-grant register resets to 1 so p0 wins the first tie.
REQ-024 SHALL sample addr/extra only at the arbitration edge; later changes have no effect on an accepted access.
REQ-025 SHALL NOT queue a request: a req dropped before grant is not serviced, and a requester keeps req high until it sees gnt.
REQ-026 SHALL ignore req inputs in ISSUE and RETURN.
REQ-027 SHALL hold mem_addr, mem_extra, rd_data and rd_error stable between updates.
REQ-028 SHALL still return rd_data when rd_error=1, and SHALL NOT retry.
REQ-029 SHALL never assert p0_gnt with p1_gnt, or p0_valid with p1_valid.

Reset
REQ-030 SHALL, while reset=0 at an edge, force: state IDLE, all gnt/valid 0, busy 0, mem_addr 0, mem_extra 0, rd_data 0, rd_error 0, last-grant 1.
REQ-031 SHALL, on reset mid-access (ISSUE or RETURN), abort the access with no valid pulse ever delivered for it.
REQ-032 SHALL allow arbitration on the first edge with reset=1.

Verification
REQ-033 SHALL cover: ROM byte i = i; p0 only, addr 2, extra 0 at edge T -> p0_gnt in cycle T+1, p0_valid in cycle T+3, rd_data[7:0]=8'h02, rd_error=0.
REQ-034 SHALL cover: p0 and p1 both requesting after reset (p0 addr 1, p1 addr 5), held until gnt -> p0 served first (rd_data[7:0]=8'h01), then p1 (8'h05); the second gnt arrives 3 cycles after the first.
REQ-035 SHALL cover: both reqs held continuously for 4 accesses -> grant order p0,p1,p0,p1 with no gnt overlap.
REQ-036 SHALL cover: p1 request to an address with rom_upper_bound=3, addr 7 -> p1_valid with rd_error=1.
REQ-037 SHALL cover: reset=0 asserted for one edge during RETURN -> no valid pulse, busy=0 next cycle, mem_addr=0.
REQ-038 SHALL cover: p0_addr changed from 2 to 9 in the cycle after the arbitration edge -> returned rd_data[7:0]=8'h02.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester, read-return and ROM-side signals of the two-port ROM arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if #(
  parameter int MEM_ADDR  = 4,
  parameter int MEM_EXTRA = 4
);
  localparam int DW = (2**MEM_EXTRA) * 8;

  logic                 p0_req;
  logic                 p1_req;
  logic [MEM_ADDR:0]    p0_addr;
  logic [MEM_ADDR:0]    p1_addr;
  logic [MEM_EXTRA-1:0] p0_extra;
  logic [MEM_EXTRA-1:0] p1_extra;
  logic                 p0_gnt;
  logic                 p1_gnt;
  logic                 p0_valid;
  logic                 p1_valid;
  logic [DW-1:0]        rd_data;
  logic                 rd_error;
  logic                 busy;
  logic [MEM_ADDR:0]    mem_addr;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic [DW-1:0]        mem_data;
  logic                 mem_error;

  modport slave (
    input  p0_req, p1_req, p0_addr, p1_addr, p0_extra, p1_extra, mem_data, mem_error,
    output p0_gnt, p1_gnt, p0_valid, p1_valid, rd_data, rd_error, busy, mem_addr, mem_extra
  );

  modport master (
    output p0_req, p1_req, p0_addr, p1_addr, p0_extra, p1_extra, mem_data, mem_error,
    input  p0_gnt, p1_gnt, p0_valid, p1_valid, rd_data, rd_error, busy, mem_addr, mem_extra
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle ROM between fetch (p0) and data (p1) requesters.
// Fixed latency: arbitration edge T, gnt in T+1, valid in T+3; no queueing, requesters hold req until gnt.
module mem_arbiter #(
  parameter int MEM_ADDR  = 4,
  parameter int MEM_EXTRA = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int DW = (2**MEM_EXTRA) * 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RETURN} state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 owner_q;
  logic                 last_gnt_q;
  logic                 valid_q;
  logic [DW-1:0]        rd_data_q;
  logic                 rd_error_q;
  logic [MEM_ADDR:0]    mem_addr_q;
  logic [MEM_EXTRA-1:0] mem_extra_q;
  logic                 arb_fire;
  logic                 arb_win;

  always_comb begin
    state_d  = state_q;
    arb_fire = 1'b0;
    arb_win  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          arb_fire = 1'b1;
          // On a tie the requester not granted last wins.
          if (bus.p0_req && bus.p1_req) arb_win = ~last_gnt_q;
          else                          arb_win = bus.p1_req;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = RETURN;
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      valid_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_error_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_extra_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == RETURN);
      if (arb_fire) begin
        owner_q     <= arb_win;
        last_gnt_q  <= arb_win;
        mem_addr_q  <= arb_win ? bus.p1_addr  : bus.p0_addr;
        mem_extra_q <= arb_win ? bus.p1_extra : bus.p0_extra;
      end
      // The ROM output for mem_addr is present during RETURN.
      if (state_q == RETURN) begin
        rd_data_q  <= bus.mem_data;
        rd_error_q <= bus.mem_error;
      end
    end
  end

  assign bus.p0_gnt    = (state_q == ISSUE) && !owner_q;
  assign bus.p1_gnt    = (state_q == ISSUE) &&  owner_q;
  assign bus.p0_valid  = valid_q && !owner_q;
  assign bus.p1_valid  = valid_q &&  owner_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_error  = rd_error_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_extra = mem_extra_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered ROM model (byte i = i, configurable upper bound).
module tb_mem_arbiter;
  localparam int MA = 4;
  localparam int ME = 4;
  localparam int DW = (2**ME) * 8;

  logic clk;
  logic reset;
  int   rom_upper_bound;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_if #(.MEM_ADDR(MA), .MEM_EXTRA(ME)) bus ();

  mem_arbiter #(.MEM_ADDR(MA), .MEM_EXTRA(ME)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_read(input logic [MA:0] addr, input logic [ME-1:0] extra);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < 2**ME; k++) begin
      if (k <= int'(extra)) w[k*8 +: 8] = 8'(int'(addr) + k);
    end
    return w;
  endfunction

  always @(posedge clk) begin
    bus.mem_data  <= rom_read(bus.mem_addr, bus.mem_extra);
    bus.mem_error <= (int'(bus.mem_addr) + int'(bus.mem_extra)) > rom_upper_bound;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.p0_req = 1'b1; bus.p1_req = 1'b1;
    bus.p0_addr = 5'd3; bus.p1_addr = 5'd3;
    tick(); tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b expected 00", {bus.p0_gnt, bus.p1_gnt}); end
    n_cmp++; if ({bus.p0_valid, bus.p1_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_valid: got %b expected 00", {bus.p0_valid, bus.p1_valid}); end
    n_cmp++; if ({bus.mem_addr, bus.mem_extra} !== 9'd0) begin n_bad++; $display("FAIL reset_mem: got %h expected 0", {bus.mem_addr, bus.mem_extra}); end
    n_cmp++; if ({bus.rd_data, bus.rd_error} !== '0) begin n_bad++; $display("FAIL reset_rd: got %h expected 0", {bus.rd_data, bus.rd_error}); end
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_p0;
    bus.p0_req = 1'b1; bus.p0_addr = 5'd2; bus.p0_extra = 4'd0;
    tick();
    n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) begin n_bad++; $display("FAIL single_gnt: got %b expected 10", {bus.p0_gnt, bus.p1_gnt}); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
    n_cmp++; if (bus.mem_addr !== 5'd2) begin n_bad++; $display("FAIL single_mem_addr: got %h expected 02", bus.mem_addr); end
    bus.p0_req = 1'b0;
    tick();
    n_cmp++; if ({bus.p0_gnt, bus.p0_valid} !== 2'b00) begin n_bad++; $display("FAIL single_ret: got gnt/valid %b expected 00", {bus.p0_gnt, bus.p0_valid}); end
    tick();
    n_cmp++; if ({bus.p0_valid, bus.p1_valid} !== 2'b10) begin n_bad++; $display("FAIL single_valid: got %b expected 10", {bus.p0_valid, bus.p1_valid}); end
    n_cmp++; if (bus.rd_data !== 128'h02) begin n_bad++; $display("FAIL single_data: got %h expected 02", bus.rd_data); end
    n_cmp++; if (bus.rd_error !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b expected 0", bus.rd_error); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy %b expected 0", bus.busy); end
    tick();
    n_cmp++; if (bus.p0_valid !== 1'b0) begin n_bad++; $display("FAIL single_pulse: got %b expected 0", bus.p0_valid); end
    n_cmp++; if (bus.rd_data !== 128'h02) begin n_bad++; $display("FAIL single_hold: got %h expected 02", bus.rd_data); end
  endtask

  task automatic test_tie;
    do_reset();
    bus.p0_req = 1'b1; bus.p0_addr = 5'd1; bus.p0_extra = 4'd0;
    bus.p1_req = 1'b1; bus.p1_addr = 5'd5; bus.p1_extra = 4'd0;
    tick();
    n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b10) begin n_bad++; $display("FAIL tie_first: got %b expected 10", {bus.p0_gnt, bus.p1_gnt}); end
    bus.p0_req = 1'b0;
    tick(); tick();
    n_cmp++; if ({bus.p0_valid, bus.p1_valid} !== 2'b10) begin n_bad++; $display("FAIL tie_valid0: got %b expected 10", {bus.p0_valid, bus.p1_valid}); end
    n_cmp++; if (bus.rd_data[7:0] !== 8'h01) begin n_bad++; $display("FAIL tie_data0: got %h expected 01", bus.rd_data[7:0]); end
    tick();
    n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b01) begin n_bad++; $display("FAIL tie_second: got %b expected 01", {bus.p0_gnt, bus.p1_gnt}); end
    bus.p1_req = 1'b0;
    tick(); tick();
    n_cmp++; if ({bus.p0_valid, bus.p1_valid} !== 2'b01) begin n_bad++; $display("FAIL tie_valid1: got %b expected 01", {bus.p0_valid, bus.p1_valid}); end
    n_cmp++; if (bus.rd_data[7:0] !== 8'h05) begin n_bad++; $display("FAIL tie_data1: got %h expected 05", bus.rd_data[7:0]); end
  endtask

  task automatic test_back_to_back;
    logic       exp_p1;
    logic [7:0] exp_byte;
    do_reset();
    bus.p0_req = 1'b1; bus.p0_addr = 5'd1; bus.p0_extra = 4'd0;
    bus.p1_req = 1'b1; bus.p1_addr = 5'd5; bus.p1_extra = 4'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_p1   = (i % 2) == 1;
      exp_byte = exp_p1 ? 8'h05 : 8'h01;
      n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== {~exp_p1, exp_p1}) begin n_bad++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, {bus.p0_gnt, bus.p1_gnt}, {~exp_p1, exp_p1}); end
      tick();
      n_cmp++; if ({bus.p0_gnt, bus.p1_gnt} !== 2'b00) begin n_bad++; $display("FAIL b2b_gap[%0d]: got %b expected 00", i, {bus.p0_gnt, bus.p1_gnt}); end
      tick();
      n_cmp++; if ({bus.p0_valid, bus.p1_valid, bus.p0_gnt, bus.p1_gnt} !== {~exp_p1, exp_p1, 2'b00}) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, {bus.p0_valid, bus.p1_valid, bus.p0_gnt, bus.p1_gnt}, {~exp_p1, exp_p1, 2'b00}); end
      n_cmp++; if (bus.rd_data[7:0] !== exp_byte) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus.rd_data[7:0], exp_byte); end
      if (i == 3) begin bus.p0_req = 1'b0; bus.p1_req = 1'b0; end
      tick();
    end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stop: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_bound_error;
    rom_upper_bound = 3;
    bus.p1_req = 1'b1; bus.p1_addr = 5'd7; bus.p1_extra = 4'd0;
    tick();
    n_cmp++; if (bus.p1_gnt !== 1'b1) begin n_bad++; $display("FAIL err_gnt: got %b expected 1", bus.p1_gnt); end
    bus.p1_req = 1'b0;
    tick(); tick();
    n_cmp++; if ({bus.p0_valid, bus.p1_valid} !== 2'b01) begin n_bad++; $display("FAIL err_valid: got %b expected 01", {bus.p0_valid, bus.p1_valid}); end
    n_cmp++; if (bus.rd_error !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b expected 1", bus.rd_error); end
    n_cmp++; if (bus.rd_data[7:0] !== 8'h07) begin n_bad++; $display("FAIL err_data: got %h expected 07", bus.rd_data[7:0]); end
    bus.p0_req = 1'b1; bus.p0_addr = 5'd3; bus.p0_extra = 4'd0;
    tick();
    bus.p0_req = 1'b0;
    tick(); tick();
    n_cmp++; if ({bus.p0_valid, bus.rd_error} !== 2'b10) begin n_bad++; $display("FAIL err_edge: got valid/err %b expected 10", {bus.p0_valid, bus.rd_error}); end
    rom_upper_bound = 31;
  endtask

  task automatic test_reset_mid;
    bus.p0_req = 1'b1; bus.p0_addr = 5'd4; bus.p0_extra = 4'd0;
    tick();
    bus.p0_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if ({bus.busy, bus.p0_valid} !== 2'b00) begin n_bad++; $display("FAIL abort_state: got busy/valid %b expected 00", {bus.busy, bus.p0_valid}); end
    n_cmp++; if (bus.mem_addr !== 5'd0) begin n_bad++; $display("FAIL abort_addr: got %h expected 00", bus.mem_addr); end
    n_cmp++; if (bus.rd_data !== '0) begin n_bad++; $display("FAIL abort_data: got %h expected 0", bus.rd_data); end
    reset = 1'b1;
    bus.p1_req = 1'b1; bus.p1_addr = 5'd6; bus.p1_extra = 4'd0;
    tick();
    n_cmp++; if ({bus.p1_gnt, bus.p0_valid} !== 2'b10) begin n_bad++; $display("FAIL abort_rearb: got gnt1/valid0 %b expected 10", {bus.p1_gnt, bus.p0_valid}); end
    bus.p1_req = 1'b0;
    tick();
    n_cmp++; if (bus.p0_valid !== 1'b0) begin n_bad++; $display("FAIL abort_novalid: got %b expected 0", bus.p0_valid); end
    tick();
    n_cmp++; if ({bus.p0_valid, bus.p1_valid} !== 2'b01) begin n_bad++; $display("FAIL abort_next: got %b expected 01", {bus.p0_valid, bus.p1_valid}); end
    n_cmp++; if (bus.rd_data[7:0] !== 8'h06) begin n_bad++; $display("FAIL abort_next_data: got %h expected 06", bus.rd_data[7:0]); end
  endtask

  task automatic test_addr_hold;
    bus.p0_req = 1'b1; bus.p0_addr = 5'd2; bus.p0_extra = 4'd1;
    tick();
    bus.p0_addr = 5'd9; bus.p0_extra = 4'd3; bus.p0_req = 1'b0;
    tick();
    n_cmp++; if ({bus.mem_addr, bus.mem_extra} !== {5'd2, 4'd1}) begin n_bad++; $display("FAIL hold_mem: got %h expected %h", {bus.mem_addr, bus.mem_extra}, {5'd2, 4'd1}); end
    tick();
    n_cmp++; if (bus.p0_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid: got %b expected 1", bus.p0_valid); end
    n_cmp++; if (bus.rd_data !== 128'h0302) begin n_bad++; $display("FAIL hold_data: got %h expected 0302", bus.rd_data); end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    rom_upper_bound = 31;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    bus.p0_addr = '0; bus.p1_addr = '0;
    bus.p0_extra = '0; bus.p1_extra = '0;
    test_reset();
    test_single_p0();
    test_tie();
    test_back_to_back();
    test_bound_error();
    test_reset_mid();
    test_addr_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
